// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C master controller
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_NACK,
    STOP,
    DONE
  } i2c_state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam int BITS_PER_BYTE = 8;

endpackage

// File: rtl/i2c_sync_2ff.sv
// rtl/i2c_sync_2ff.sv - two-flop synchronizer for a raw bus line, resets to the released level
module i2c_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// rtl/i2c_master_ctrl.sv - single-byte I2C master: START, addr/RW, one data byte, STOP
module i2c_master_ctrl #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       busy,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe
);
  import i2c_pkg::*;

  localparam logic [15:0] TERM     = 16'(CLK_DIV - 1);
  localparam logic [2:0]  LAST_BIT = 3'(BITS_PER_BYTE - 1);

  i2c_state_t state, state_nxt;
  logic [1:0]  qtr;
  logic [15:0] tcnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  tx_sr, rx_sr, wdata_q;
  logic        rw_q, nack_q;
  logic        scl_s, sda_s;
  logic        accept, tick_end, q_done, slot_done;

  i2c_sync_2ff u_scl_sync (.clk(clk), .rst(rst), .d(scl_i), .q(scl_s));
  i2c_sync_2ff u_sda_sync (.clk(clk), .rst(rst), .d(sda_i), .q(sda_s));

  assign accept    = (state == IDLE) && cmd_valid;
  assign tick_end  = (tcnt == TERM);
  assign slot_done = q_done && (qtr == Q3);

  // A quarter ends at terminal count unless a slave stretches SCL in q2
  // or the bus is not idle when a START is about to be issued.
  always_comb begin
    q_done = tick_end;
    if (qtr == Q2 && !scl_s) q_done = 1'b0;
    if (state == START && qtr == Q0 && !(scl_s && sda_s)) q_done = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      qtr       <= Q0;
      tcnt      <= '0;
      bit_cnt   <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      wdata_q   <= '0;
      rw_q      <= 1'b0;
      nack_q    <= 1'b0;
      rsp_rdata <= '0;
      rsp_nack  <= 1'b0;
    end else begin
      state <= state_nxt;

      // The handshake cycle is counted as the first cycle of START q0.
      if (state == IDLE || state == DONE) begin
        qtr  <= Q0;
        tcnt <= accept ? 16'd1 : 16'd0;
      end else if (q_done) begin
        qtr  <= qtr + 2'd1;
        tcnt <= '0;
      end else if (!tick_end) begin
        tcnt <= tcnt + 16'd1;
      end

      if (accept) begin
        tx_sr   <= {cmd_addr, cmd_rw};
        wdata_q <= cmd_wdata;
        rw_q    <= cmd_rw;
        nack_q  <= 1'b0;
        bit_cnt <= '0;
      end

      if (slot_done) begin
        case (state)
          ADDR, WDATA, RDATA: begin
            bit_cnt <= bit_cnt + 3'd1;
            tx_sr   <= {tx_sr[6:0], 1'b0};
            rx_sr   <= {rx_sr[6:0], sda_s};
          end
          ADDR_ACK: begin
            nack_q <= sda_s;
            tx_sr  <= wdata_q;
          end
          WDATA_ACK: nack_q <= sda_s;
          STOP: begin
            rsp_nack  <= nack_q;
            rsp_rdata <= (rw_q && !nack_q) ? rx_sr : 8'h00;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_nxt = state;
    scl_oe    = 1'b0;
    sda_oe    = 1'b0;
    case (state)
      IDLE: if (cmd_valid) state_nxt = START;
      START: begin
        sda_oe = (qtr >= Q2);
        if (slot_done) state_nxt = ADDR;
      end
      ADDR: begin
        scl_oe = (qtr < Q2);
        sda_oe = !tx_sr[7];
        if (slot_done && bit_cnt == LAST_BIT) state_nxt = ADDR_ACK;
      end
      ADDR_ACK: begin
        scl_oe = (qtr < Q2);
        if (slot_done) state_nxt = sda_s ? STOP : (rw_q ? RDATA : WDATA);
      end
      WDATA: begin
        scl_oe = (qtr < Q2);
        sda_oe = !tx_sr[7];
        if (slot_done && bit_cnt == LAST_BIT) state_nxt = WDATA_ACK;
      end
      WDATA_ACK: begin
        scl_oe = (qtr < Q2);
        if (slot_done) state_nxt = STOP;
      end
      RDATA: begin
        scl_oe = (qtr < Q2);
        if (slot_done && bit_cnt == LAST_BIT) state_nxt = RDATA_NACK;
      end
      RDATA_NACK: begin
        scl_oe = (qtr < Q2);
        if (slot_done) state_nxt = STOP;
      end
      STOP: begin
        scl_oe = (qtr < Q2);
        sda_oe = (qtr != Q3);
        if (slot_done) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == DONE);

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb/tb_i2c_master_ctrl.sv - self-checking bench for i2c_master_ctrl with a behavioural slave
module tb_i2c_master_ctrl;

  localparam int D = 4;
  localparam int P_IDLE = 0, P_ADDR = 1, P_AACK = 2, P_WDATA = 3, P_WACK = 4, P_RDATA = 5, P_RNACK = 6;

  logic       clk = 0, rst = 1;
  logic       cmd_valid = 0, cmd_rw = 0;
  logic [6:0] cmd_addr = 0;
  logic [7:0] cmd_wdata = 0;
  logic       cmd_ready, rsp_valid, rsp_nack, busy, scl_oe, sda_oe;
  logic [7:0] rsp_rdata;

  logic sl_sda = 0, sl_scl_hold = 0;
  wire  bus_scl = ~(scl_oe | sl_scl_hold);
  wire  bus_sda = ~(sda_oe | sl_sda);

  i2c_master_ctrl #(.CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack), .busy(busy),
    .scl_i(bus_scl), .sda_i(bus_sda), .scl_oe(scl_oe), .sda_oe(sda_oe)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Behavioural slave: watches bus levels once per clock and reacts on SCL edges.
  bit         sl_present = 0, sl_data_ack = 1, stretch_en = 0;
  logic [6:0] sl_addr = 0;
  logic [7:0] sl_rd_byte = 0;
  int         phase = P_IDLE, nbits = 0, stretch_cnt = 0, start_cnt = 0, stop_cnt = 0;
  bit         prev_scl = 1, prev_sda = 1, c_scl, c_sda, addr_acked, rd_mode, master_nack_bit;
  logic [7:0] shreg;
  logic [7:0] bus_bytes[$];

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      phase = P_IDLE; sl_sda = 0; sl_scl_hold = 0; stretch_cnt = 0; prev_scl = 1; prev_sda = 1;
    end else begin
      c_scl = bus_scl;
      c_sda = bus_sda;
      if (prev_scl && c_scl && prev_sda && !c_sda) begin
        start_cnt++; phase = P_ADDR; nbits = 0;
      end else if (prev_scl && c_scl && !prev_sda && c_sda) begin
        stop_cnt++; phase = P_IDLE; sl_sda = 0;
      end else if (!prev_scl && c_scl) begin
        if (phase == P_ADDR || phase == P_WDATA) begin
          shreg = {shreg[6:0], c_sda}; nbits++;
        end else if (phase == P_RDATA) nbits++;
        else if (phase == P_RNACK) master_nack_bit = c_sda;
      end else if (prev_scl && !c_scl) begin
        case (phase)
          P_ADDR: if (nbits == 8) begin
            bus_bytes.push_back(shreg);
            addr_acked = sl_present && (shreg[7:1] == sl_addr);
            rd_mode = shreg[0]; sl_sda = addr_acked; phase = P_AACK;
          end
          P_AACK: begin
            sl_sda = 0; nbits = 0;
            if (!addr_acked) phase = P_IDLE;
            else if (rd_mode) begin phase = P_RDATA; sl_sda = !sl_rd_byte[7]; end
            else phase = P_WDATA;
          end
          P_WDATA: if (nbits == 8) begin
            bus_bytes.push_back(shreg); sl_sda = sl_data_ack; phase = P_WACK;
          end
          P_WACK:  begin sl_sda = 0; phase = P_IDLE; end
          P_RDATA: if (nbits == 8) begin sl_sda = 0; phase = P_RNACK; end
                   else sl_sda = !sl_rd_byte[7 - nbits];
          P_RNACK: phase = P_IDLE;
          default: ;
        endcase
        if (stretch_en && phase == P_WDATA && nbits == 3) begin
          sl_scl_hold = 1; stretch_en = 0; stretch_cnt = -1;
        end
      end
      // Keep SCL low for 51 clocks after the master lets go of it.
      if (sl_scl_hold) begin
        if (stretch_cnt < 0) begin
          if (!scl_oe) stretch_cnt = 51;
        end else begin
          stretch_cnt--;
          if (stretch_cnt == 0) sl_scl_hold = 0;
        end
      end
      prev_scl = c_scl;
      prev_sda = c_sda;
    end
  end

  typedef struct {
    logic [6:0] addr; logic rw; logic [7:0] wdata;
    bit present; bit dack; logic [7:0] rdb; bit stretch;
    logic exp_nack; logic [7:0] exp_rdata; int exp_lat; int exp_nbytes;
    logic [7:0] exp_b0; logic [7:0] exp_b1;
  } vec_t;

  vec_t vecs[6];

  // Expected outcome of a transaction, derived from the protocol rules alone.
  function automatic vec_t ref_txn(input logic [6:0] a, input logic r, input logic [7:0] w,
                                   input bit pres, input bit dack, input logic [7:0] rdb);
    vec_t v;
    v.addr = a; v.rw = r; v.wdata = w; v.present = pres; v.dack = dack; v.rdb = rdb; v.stretch = 0;
    v.exp_lat    = pres ? 80 * D : 44 * D;
    v.exp_nack   = !pres || (!r && !dack);
    v.exp_rdata  = (pres && r) ? rdb : 8'h00;
    v.exp_nbytes = (pres && !r) ? 2 : 1;
    v.exp_b0 = {a, r};
    v.exp_b1 = w;
    return v;
  endfunction

  task automatic do_txn(input logic [6:0] a, input logic r, input logic [7:0] w,
                        output int lat, output logic nk, output logic [7:0] rd, output int rbad);
    lat = -1; nk = 0; rd = 0; rbad = 0;
    bus_bytes.delete(); start_cnt = 0; stop_cnt = 0; master_nack_bit = 0;
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
    cmd_addr = a; cmd_rw = r; cmd_wdata = w; cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0; cmd_addr = 7'($urandom); cmd_rw = 1'($urandom); cmd_wdata = 8'($urandom);
    for (int n = 1; n <= 2000; n++) begin
      if (rsp_valid) begin lat = n; nk = rsp_nack; rd = rsp_rdata; break; end
      if (cmd_ready || !busy) rbad++;
      @(negedge clk);
    end
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    int lat, rbad;
    logic nk;
    logic [7:0] rd, b0, b1;
    sl_present = v.present; sl_addr = v.addr; sl_data_ack = v.dack; sl_rd_byte = v.rdb;
    stretch_en = v.stretch;
    do_txn(v.addr, v.rw, v.wdata, lat, nk, rd, rbad);
    stretch_en = 0;
    if (v.stretch) chk_range({tag, "_lat"}, lat, v.exp_lat + 50, v.exp_lat + 52);
    else           chk({tag, "_lat"}, lat, v.exp_lat);
    chk({tag, "_nack"}, nk, v.exp_nack);
    chk({tag, "_rdata"}, rd, v.exp_rdata);
    chk({tag, "_ready_busy"}, rbad, 0);
    chk({tag, "_nbytes"}, bus_bytes.size(), v.exp_nbytes);
    b0 = (bus_bytes.size() > 0) ? bus_bytes[0] : 8'h00;
    b1 = (bus_bytes.size() > 1) ? bus_bytes[1] : 8'h00;
    chk({tag, "_byte0"}, b0, v.exp_b0);
    if (v.exp_nbytes == 2) chk({tag, "_byte1"}, b1, v.exp_b1);
    chk({tag, "_starts"}, start_cnt, 1);
    chk({tag, "_stops"}, stop_cnt, 1);
    if (v.rw && v.present) chk({tag, "_master_nack"}, master_nack_bit, 1);
    @(negedge clk);
    chk({tag, "_pulse"}, rsp_valid, 0);
    chk({tag, "_hold"}, {rsp_nack, rsp_rdata}, {v.exp_nack, v.exp_rdata});
  endtask

  initial begin
    int lat, rbad, pulses;
    bit hit;
    vec_t rv;

    //        addr   rw wdata  pr dk rdb    st nack rdata  lat    nb b0     b1
    vecs[0] = '{7'h50, 0, 8'hA5, 1, 1, 8'h00, 0, 0, 8'h00, 80*D, 2, 8'hA0, 8'hA5};
    vecs[1] = '{7'h28, 1, 8'h00, 1, 1, 8'h3C, 0, 0, 8'h3C, 80*D, 1, 8'h51, 8'h00};
    vecs[2] = '{7'h7F, 0, 8'h99, 0, 1, 8'h00, 0, 1, 8'h00, 44*D, 1, 8'hFE, 8'h00};
    vecs[3] = '{7'h50, 0, 8'h3C, 1, 0, 8'h00, 0, 1, 8'h00, 80*D, 2, 8'hA0, 8'h3C};
    vecs[4] = '{7'h11, 1, 8'h00, 0, 1, 8'hFF, 0, 1, 8'h00, 44*D, 1, 8'h23, 8'h00};
    vecs[5] = '{7'h50, 0, 8'h5A, 1, 1, 8'h00, 1, 0, 8'h00, 80*D, 2, 8'hA0, 8'h5A};

    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("reset_ready", cmd_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_oe", {scl_oe, sda_oe}, 0);
    chk("reset_rsp", {rsp_valid, rsp_nack, rsp_rdata}, 0);

    for (int i = 0; i < 6; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 16; i++) begin
      rv = ref_txn(7'($urandom), 1'($urandom), 8'($urandom),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 8'($urandom));
      apply_vec(rv, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of data bit 4 must release the bus asynchronously.
    sl_present = 1; sl_addr = 7'h50; sl_data_ack = 1;
    cmd_addr = 7'h50; cmd_rw = 0; cmd_wdata = 8'h00; cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
    hit = 0;
    for (int i = 0; i < 1000; i++) begin
      if (phase == P_WDATA && nbits == 4 && scl_oe) begin hit = 1; break; end
      @(negedge clk);
    end
    chk("rst_reach_bit4", hit, 1);
    chk("rst_pre_oe", {scl_oe, sda_oe}, 2'b11);
    #2 rst = 1;
    #1;
    chk("rst_async_oe", {scl_oe, sda_oe}, 0);
    chk("rst_async_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_after_ready", cmd_ready, 1);
    pulses = 0;
    for (int i = 0; i < 400; i++) begin
      if (rsp_valid) pulses++;
      @(negedge clk);
    end
    chk("rst_no_rsp", pulses, 0);
    apply_vec(vecs[0], "post_rst");

    // Two commands queued behind a held cmd_valid.
    sl_present = 1; sl_addr = 7'h50; sl_data_ack = 1;
    bus_bytes.delete();
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
    cmd_addr = 7'h50; cmd_rw = 0; cmd_wdata = 8'h11; cmd_valid = 1;
    @(negedge clk);
    cmd_wdata = 8'h22;
    lat = -1; rbad = 0;
    for (int n = 1; n <= 2000; n++) begin
      if (rsp_valid) begin lat = n; break; end
      if (cmd_ready) rbad++;
      @(negedge clk);
    end
    chk("queue_lat1", lat, 80 * D);
    chk("queue_ready_low", rbad, 0);
    @(negedge clk);
    chk("queue_second_hs", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 0;
    lat = -1;
    for (int n = 1; n <= 2000; n++) begin
      if (rsp_valid) begin lat = n; break; end
      @(negedge clk);
    end
    chk("queue_lat2", lat, 80 * D);
    chk("queue_nbytes", bus_bytes.size(), 4);
    if (bus_bytes.size() == 4) begin
      chk("queue_data1", bus_bytes[1], 8'h11);
      chk("queue_data2", bus_bytes[3], 8'h22);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
